// File: rtl/sram_read_arbiter_if.sv
// sram_read_arbiter_if: bundle between the pass sequencing controller, the
// input-SRAM read port and the read arbiter.
// Optional build macro: ARB_STATS_EN adds the grant/stall statistics counters.
//
// Handshake: req[i] is a level "valid" for requester i and gnt[i] is the
// combinational "ready" for it. Exactly one read is accepted for requester i
// on every rising clock edge where req[i] && gnt[i]; a requester keeps req[i]
// high for further reads. The matching rvalid[i] pulses READ_LAT cycles after
// the grant, with rdata holding the word for that read.
interface sram_read_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              flush;
  logic [2:0]        req;
  logic [2:0]        lock;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [2:0]        gnt;
  logic [ADDR_W-1:0] sram_read_addr;
  logic [DATA_W-1:0] sram_read_data;
  logic [2:0]        rvalid;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  // debug visibility of the arbitration FSM
  logic [1:0]        dbg_state;
  logic [1:0]        dbg_rr_ptr;
`ifdef ARB_STATS_EN
  logic [15:0]       stat_gnt0;
  logic [15:0]       stat_gnt1;
  logic [15:0]       stat_gnt2;
  logic [15:0]       stat_stall;
`endif

  // arbiter side
  modport slave (
    input  flush, req, lock, addr0, addr1, addr2, sram_read_data,
    output gnt, sram_read_addr, rvalid, rdata, busy, dbg_state, dbg_rr_ptr
`ifdef ARB_STATS_EN
    , output stat_gnt0, stat_gnt1, stat_gnt2, stat_stall
`endif
  );

  // controller / SRAM side
  modport master (
    output flush, req, lock, addr0, addr1, addr2, sram_read_data,
    input  gnt, sram_read_addr, rvalid, rdata, busy, dbg_state, dbg_rr_ptr
`ifdef ARB_STATS_EN
    , input stat_gnt0, stat_gnt1, stat_gnt2, stat_stall
`endif
  );
endinterface

// File: rtl/sram_read_arbiter.sv
// sram_read_arbiter: shares the single input-SRAM read port between the
// input fetch (0), weight fetch (1) and scratchpad fetch (2) requesters.
// Round-robin grant with an optional burst lock, read data returned to the
// owner READ_LAT cycles after its grant.
// Optional build macro: ARB_STATS_EN (per-requester grant counters and a
// stall counter, all saturating, cleared only by reset).
module sram_read_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1,
  parameter int LOCK_MAX = 16
) (
  input logic              clock,
  input logic              reset,
  sram_read_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  // a lock of length one is no lock at all
  localparam bit LOCK_EN = (LOCK_MAX > 1);

  function automatic logic [2:0] idx_to_oh(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  logic [1:0]       rr_base;
  logic [1:0]       rr_win;
  logic             rr_any;
  logic [2:0]       gnt_c;
  logic [1:0]       gnt_idx;
  logic [2:0]       gnt_o;
  logic             in_lock;
  logic             owner_hold;
  logic             others_pending;
  logic             cnt_at_max;

  logic [READ_LAT-1:0] pv_q, pv_d;
  logic [1:0]          po_q [READ_LAT];
  logic                busy_q;

  // While locked the owner sits at lowest priority, so any exit re-arbitrates
  // as if the owner had just been granted.
  assign in_lock        = (state_q == ST_LOCKED);
  assign rr_base        = in_lock ? owner_q : rr_ptr_q;
  assign others_pending = |(bus.req & ~idx_to_oh(owner_q));
  assign cnt_at_max     = (lock_cnt_q == CNT_MAX);
  assign owner_hold     = in_lock && bus.req[owner_q] && !(cnt_at_max && others_pending);

  // Round-robin pick: first requester after rr_base, wrapping mod 3.
  always_comb begin
    rr_win = 2'd0;
    rr_any = |bus.req;
    case (rr_base)
      2'd0: begin
        if (bus.req[1])      rr_win = 2'd1;
        else if (bus.req[2]) rr_win = 2'd2;
        else                 rr_win = 2'd0;
      end
      2'd1: begin
        if (bus.req[2])      rr_win = 2'd2;
        else if (bus.req[0]) rr_win = 2'd0;
        else                 rr_win = 2'd1;
      end
      default: begin
        if (bus.req[0])      rr_win = 2'd0;
        else if (bus.req[1]) rr_win = 2'd1;
        else                 rr_win = 2'd2;
      end
    endcase
  end

  // Next-state, lock bookkeeping and combinational grant.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    gnt_c      = 3'b000;
    gnt_idx    = 2'd0;
    if (bus.flush) begin
      // abort: no grant, release lock, keep the pointer
      state_d    = ST_IDLE;
      lock_cnt_d = '0;
    end else if (owner_hold) begin
      gnt_c   = idx_to_oh(owner_q);
      gnt_idx = owner_q;
      if (!cnt_at_max) lock_cnt_d = lock_cnt_q + CNT_ONE;
      if (!bus.lock[owner_q]) begin
        state_d    = ST_GRANT;
        rr_ptr_d   = owner_q;
        lock_cnt_d = '0;
      end
    end else begin
      if (in_lock) rr_ptr_d = owner_q;
      lock_cnt_d = '0;
      if (rr_any) begin
        gnt_c    = idx_to_oh(rr_win);
        gnt_idx  = rr_win;
        rr_ptr_d = rr_win;
        if (LOCK_EN && bus.lock[rr_win]) begin
          state_d    = ST_LOCKED;
          owner_d    = rr_win;
          lock_cnt_d = CNT_ONE;
        end else begin
          state_d = ST_GRANT;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Arbitration state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= 2'd2;
      owner_q    <= 2'd0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // No grant is issued while reset is held, so nothing enters the pipeline.
  assign gnt_o = reset ? 3'b000 : gnt_c;

  // Return pipeline valids: new grant enters stage 0, flush empties it.
  always_comb begin
    pv_d    = '0;
    pv_d[0] = |gnt_o;
    for (int i = 1; i < READ_LAT; i++) pv_d[i] = pv_q[i-1];
    if (bus.flush) pv_d = '0;
  end

  // Return pipeline registers and registered busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      pv_q   <= '0;
      busy_q <= 1'b0;
      for (int i = 0; i < READ_LAT; i++) po_q[i] <= 2'd0;
    end else begin
      pv_q   <= pv_d;
      busy_q <= (|bus.req) || (|pv_d);
      po_q[0] <= gnt_idx;
      for (int i = 1; i < READ_LAT; i++) po_q[i] <= po_q[i-1];
    end
  end

  // Address mux for the granted requester, zero when idle.
  always_comb begin
    bus.sram_read_addr = '0;
    if (gnt_o[0])      bus.sram_read_addr = bus.addr0;
    else if (gnt_o[1]) bus.sram_read_addr = bus.addr1;
    else if (gnt_o[2]) bus.sram_read_addr = bus.addr2;
  end

  assign bus.gnt        = gnt_o;
  assign bus.rvalid     = pv_q[READ_LAT-1] ? idx_to_oh(po_q[READ_LAT-1]) : 3'b000;
  assign bus.rdata      = bus.sram_read_data;
  assign bus.busy       = busy_q;
  assign bus.dbg_state  = state_q;
  assign bus.dbg_rr_ptr = rr_ptr_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_g0_q, stat_g1_q, stat_g2_q, stat_stall_q;
  logic        stall_c;

  assign stall_c = |(bus.req & ~gnt_o);

  // Saturating grant and stall counters; flush does not clear them.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_g0_q    <= '0;
      stat_g1_q    <= '0;
      stat_g2_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      if (gnt_o[0] && stat_g0_q != 16'hFFFF) stat_g0_q <= stat_g0_q + 16'd1;
      if (gnt_o[1] && stat_g1_q != 16'hFFFF) stat_g1_q <= stat_g1_q + 16'd1;
      if (gnt_o[2] && stat_g2_q != 16'hFFFF) stat_g2_q <= stat_g2_q + 16'd1;
      if (stall_c && stat_stall_q != 16'hFFFF) stat_stall_q <= stat_stall_q + 16'd1;
    end
  end

  assign bus.stat_gnt0  = stat_g0_q;
  assign bus.stat_gnt1  = stat_g1_q;
  assign bus.stat_gnt2  = stat_g2_q;
  assign bus.stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_sram_read_arbiter.sv
// tb_sram_read_arbiter: table-driven vectors, hand sequences for lock,
// latency, flush and reset corners, then sticky random traffic checked
// against a behavioural arbitration model with a return queue.
module tb_sram_read_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int RL = 2;
  localparam int LM = 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sram_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_read_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .LOCK_MAX(LM)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- SRAM model ----------------
  function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a);
    return {a[3:0], a} ^ 16'h5A3C;
  endfunction

  logic [AW-1:0] addr_hist [RL];
  always @(posedge clock) begin
    addr_hist[0] <= bus.sram_read_addr;
    for (int i = 1; i < RL; i++) addr_hist[i] <= addr_hist[i-1];
  end
  assign bus.sram_read_data = sram_word(addr_hist[RL-1]);

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    int            due;
    logic [2:0]    owner_oh;
    logic [DW-1:0] data;
  } ret_t;
  ret_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int m_ptr, m_owner, m_cnt;
  bit m_locked, m_busy;
  int m_sg [3];
  int m_stall;

  logic [2:0]    obs_gnt, obs_rvalid;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_rdata;
  logic          obs_busy;
  logic [1:0]    obs_state, obs_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr = 2; m_owner = 0; m_cnt = 0; m_locked = 0; m_busy = 0;
    m_sg[0] = 0; m_sg[1] = 0; m_sg[2] = 0; m_stall = 0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic run_cycle(input logic [2:0] r, input logic [2:0] l, input logic f,
                           input logic rs, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [AW-1:0] a2);
    logic [2:0]    exp_g, exp_rv, own_oh;
    logic [DW-1:0] exp_rd;
    logic [AW-1:0] exp_a;
    int win, base, idx;
    bus.req = r; bus.lock = l; bus.flush = f; reset = rs;
    bus.addr0 = a0; bus.addr1 = a1; bus.addr2 = a2;

    exp_rv = 3'b000; exp_rd = '0;
    foreach (exp_q[k]) if (exp_q[k].due == cyc) begin
      exp_rv = exp_q[k].owner_oh; exp_rd = exp_q[k].data;
    end

    win = -1;
    own_oh = 3'(3'b001 << m_owner);
    if (!rs && !f) begin
      if (m_locked && r[m_owner] && !(m_cnt == LM && (r & ~own_oh) != 3'b000)) begin
        win = m_owner;
        if (m_cnt < LM) m_cnt++;
        if (!l[m_owner]) begin m_locked = 0; m_ptr = m_owner; end
      end else begin
        base = m_locked ? m_owner : m_ptr;
        if (m_locked) m_ptr = m_owner;
        m_locked = 0;
        for (int k = 1; k <= 3; k++) begin
          idx = (base + k) % 3;
          if (win < 0 && r[idx]) win = idx;
        end
        if (win >= 0) begin
          m_ptr = win;
          if (l[win] && LM > 1) begin m_locked = 1; m_owner = win; m_cnt = 1; end
        end
      end
    end
    exp_g = (win < 0) ? 3'b000 : 3'(3'b001 << win);
    exp_a = (win == 0) ? a0 : (win == 1) ? a1 : (win == 2) ? a2 : '0;

    @(negedge clock);
    obs_gnt = bus.gnt; obs_rvalid = bus.rvalid; obs_addr = bus.sram_read_addr;
    obs_rdata = bus.rdata; obs_busy = bus.busy;
    obs_state = bus.dbg_state; obs_ptr = bus.dbg_rr_ptr;
    check("gnt", 32'(obs_gnt), 32'(exp_g));
    check("sram_read_addr", 32'(obs_addr), 32'(exp_a));
    check("rvalid", 32'(obs_rvalid), 32'(exp_rv));
    if (exp_rv != 3'b000) check("rdata", 32'(obs_rdata), 32'(exp_rd));
    check("busy", 32'(obs_busy), 32'(m_busy));
`ifdef ARB_STATS_EN
    check("stat_gnt0", 32'(bus.stat_gnt0), 32'(m_sg[0]));
    check("stat_gnt1", 32'(bus.stat_gnt1), 32'(m_sg[1]));
    check("stat_gnt2", 32'(bus.stat_gnt2), 32'(m_sg[2]));
    check("stat_stall", 32'(bus.stat_stall), 32'(m_stall));
`endif

    // advance the model across the coming edge
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
    if (rs) begin
      model_reset();
    end else begin
      if (win >= 0 && m_sg[win] < 16'hFFFF) m_sg[win]++;
      if ((r & ~exp_g) != 3'b000 && m_stall < 16'hFFFF) m_stall++;
      if (f) begin
        exp_q.delete();
        m_locked = 0;
      end else if (win >= 0) begin
        exp_q.push_back('{due: cyc + RL, owner_oh: exp_g, data: sram_word(exp_a)});
      end
      m_busy = (r != 3'b000) || (exp_q.size() > 0);
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(3'b000, 3'b000, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] req;
    logic [2:0] exp_gnt;
    logic [2:0] exp_rvalid;
    logic       exp_busy;
  } vec_t;
  vec_t vecs [9];

  initial begin
    logic [2:0] rq, lk;
    logic [AW-1:0] ra;

    vecs[0] = '{3'b111, 3'b001, 3'b000, 1'b0};
    vecs[1] = '{3'b111, 3'b010, 3'b000, 1'b1};
    vecs[2] = '{3'b111, 3'b100, 3'b001, 1'b1};
    vecs[3] = '{3'b111, 3'b001, 3'b010, 1'b1};
    vecs[4] = '{3'b111, 3'b010, 3'b100, 1'b1};
    vecs[5] = '{3'b111, 3'b100, 3'b001, 1'b1};
    vecs[6] = '{3'b000, 3'b000, 3'b010, 1'b1};
    vecs[7] = '{3'b000, 3'b000, 3'b100, 1'b1};
    vecs[8] = '{3'b000, 3'b000, 3'b000, 1'b0};

    reset = 1'b1; bus.req = '0; bus.lock = '0; bus.flush = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.addr2 = '0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();

    // reset values
    idle(1);
    check("rst_gnt", 32'(obs_gnt), 32'd0);
    check("rst_rvalid", 32'(obs_rvalid), 32'd0);
    check("rst_busy", 32'(obs_busy), 32'd0);
    check("rst_addr", 32'(obs_addr), 32'd0);
    check("rst_state", 32'(obs_state), 32'd0);
    check("rst_rr_ptr", 32'(obs_ptr), 32'd2);

    // round-robin rotation, returns delayed by RL
    for (int i = 0; i < 9; i++) begin
      run_cycle(vecs[i].req, 3'b000, 1'b0, 1'b0, AW'($urandom), AW'($urandom), AW'($urandom));
      check("tbl_gnt", 32'(obs_gnt), 32'(vecs[i].exp_gnt));
      check("tbl_rvalid", 32'(obs_rvalid), 32'(vecs[i].exp_rvalid));
      check("tbl_busy", 32'(obs_busy), 32'(vecs[i].exp_busy));
    end

    // burst lock: 16 grants to requester 1, one to requester 0, then back
    run_cycle(3'b010, 3'b010, 1'b0, 1'b0, 12'h100, 12'h200, 12'h300);
    check("lock_first", 32'(obs_gnt), 32'b010);
    for (int i = 0; i < 19; i++) begin
      run_cycle(3'b011, 3'b010, 1'b0, 1'b0, 12'h100, AW'(12'h201 + i), 12'h300);
      check("lock_seq", 32'(obs_gnt), (i == 15) ? 32'b001 : 32'b010);
    end
    idle(4);

    // single requester 2 latency and data return
    run_cycle(3'b100, 3'b000, 1'b0, 1'b0, 12'h011, 12'h022, 12'h0A5);
    check("lat_gnt", 32'(obs_gnt), 32'b100);
    check("lat_addr", 32'(obs_addr), 32'h0A5);
    idle(1);
    check("lat_early", 32'(obs_rvalid), 32'd0);
    idle(1);
    check("lat_rvalid", 32'(obs_rvalid), 32'b100);
    check("lat_rdata", 32'(obs_rdata), 32'(sram_word(12'h0A5)));
    idle(2);

    // flush drops in-flight returns
    run_cycle(3'b001, 3'b000, 1'b0, 1'b0, 12'h0F0, '0, '0);
    check("fl_gnt0", 32'(obs_gnt), 32'b001);
    run_cycle(3'b001, 3'b000, 1'b1, 1'b0, 12'h0F1, '0, '0);
    check("fl_gnt_blocked", 32'(obs_gnt), 32'd0);
    idle(1);
    check("fl_rvalid_t2", 32'(obs_rvalid), 32'd0);
    check("fl_state", 32'(obs_state), 32'd0);
    check("fl_busy_t2", 32'(obs_busy), 32'd1);
    idle(1);
    check("fl_rvalid_t3", 32'(obs_rvalid), 32'd0);
    check("fl_busy_t3", 32'(obs_busy), 32'd0);

    // reset in the middle of a locked burst
    for (int i = 0; i < 3; i++) run_cycle(3'b001, 3'b001, 1'b0, 1'b0, AW'(i), '0, '0);
    check("mb_locked", 32'(obs_state), 32'd2);
    run_cycle(3'b001, 3'b001, 1'b0, 1'b1, 12'h003, '0, '0);
    check("mb_rst_gnt", 32'(obs_gnt), 32'd0);
    idle(1);
    check("mb_gnt", 32'(obs_gnt), 32'd0);
    check("mb_rvalid", 32'(obs_rvalid), 32'd0);
    check("mb_busy", 32'(obs_busy), 32'd0);
    check("mb_state", 32'(obs_state), 32'd0);
    check("mb_rr_ptr", 32'(obs_ptr), 32'd2);
    run_cycle(3'b110, 3'b000, 1'b0, 1'b0, '0, 12'h555, 12'h666);
    check("mb_first", 32'(obs_gnt), 32'b010);

    // two requesters alternate; stall counted every cycle
    run_cycle(3'b000, 3'b000, 1'b0, 1'b1, '0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      run_cycle(3'b011, 3'b000, 1'b0, 1'b0, AW'(i), AW'(i + 64), '0);
      check("alt_gnt", 32'(obs_gnt), (i % 2 == 0) ? 32'b001 : 32'b010);
    end
    idle(1);
`ifdef ARB_STATS_EN
    check("st_gnt0", 32'(bus.stat_gnt0), 32'd5);
    check("st_gnt1", 32'(bus.stat_gnt1), 32'd5);
    check("st_gnt2", 32'(bus.stat_gnt2), 32'd0);
    check("st_stall", 32'(bus.stat_stall), 32'd10);
`endif

    // sticky random traffic against the model
    rq = 3'b000;
    for (int i = 0; i < 600; i++) begin
      rq = rq ^ (3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)));
      lk = 3'($urandom_range(0, 7)) | 3'($urandom_range(0, 7));
      ra = AW'($urandom);
      run_cycle(rq, lk, ($urandom_range(0, 29) == 0), ($urandom_range(0, 149) == 0),
                ra, AW'($urandom), AW'($urandom));
    end
    idle(RL + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
